meatsquare_datapath: RTL and testbench

- Datapath partner of the game controller FSM.
- Consumes the controller's one-cycle command pulses (update, plot+draw, plot+erase, reset_count) and holds the falling square's position.
- Sweeps the square's pixels to the VGA adapter write port and returns the status flags finish_counting and finish_game.
- Queues one plot request, because the controller never waits for a sweep to finish.

---
 rtl/meatsquare_datapath.sv | 208 ++++++++++++++++++++
 tb/tb_meatsquare_datapath.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/meatsquare_datapath.sv
// Datapath for the falling-square game: holds the square position, runs the frame
// delay counter and sweeps square pixels to the VGA write port with a one-deep request queue.
module meatsquare_datapath #(
   parameter int         SCREEN_W    = 160,
   parameter int         SCREEN_H    = 120,
   parameter int         SQ_SIZE     = 4,
   parameter int         X_START     = 78,
   parameter int         FRAME_DELAY = 833333,
   parameter logic [2:0] SQ_COLOUR   = 3'b100
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       update,
   input  logic       plot,
   input  logic       draw,
   input  logic       erase,
   input  logic       reset_count,
   input  logic       left,
   input  logic       right,
   output logic [7:0] x,
   output logic [6:0] y,
   output logic [2:0] colour,
   output logic       writeEn,
   output logic       finish_counting,
   output logic       finish_game,
   output logic       overflow
);

   localparam int SQ_LOG = $clog2(SQ_SIZE);
   localparam int IDX_W  = 2 * SQ_LOG;
   localparam int CNT_W  = (FRAME_DELAY > 1) ? $clog2(FRAME_DELAY) : 1;

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FRAME_DELAY - 1);
   localparam logic [7:0]       X_MAX   = 8'(SCREEN_W - SQ_SIZE);
   localparam logic [7:0]       X_INIT  = 8'(X_START);
   localparam logic [7:0]       SQ_EDGE = 8'(SQ_SIZE);
   localparam logic [7:0]       Y_LIMIT = 8'(SCREEN_H);

   typedef enum logic {S_IDLE, S_SWEEP} state_t;

   state_t             state_q, state_d;
   logic [7:0]         sq_x_q, sq_x_d;
   logic [6:0]         sq_y_q, sq_y_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [7:0]         snap_x_q, snap_x_d;
   logic [6:0]         snap_y_q, snap_y_d;
   logic               snap_draw_q, snap_draw_d;
   logic               pend_full_q, pend_full_d;
   logic [7:0]         pend_x_q, pend_x_d;
   logic [6:0]         pend_y_q, pend_y_d;
   logic               pend_draw_q, pend_draw_d;
   logic [7:0]         x_q, x_d;
   logic [6:0]         y_q, y_d;
   logic [2:0]         colour_q, colour_d;
   logic               we_q, we_d;
   logic               ovf_q, ovf_d;

   logic               req;
   logic               start;
   logic [7:0]         start_x;
   logic [6:0]         start_y;
   logic               start_draw;

   assign req         = plot & (draw | erase);
   assign finish_game = ({1'b0, sq_y_q} + SQ_EDGE) >= Y_LIMIT;

   always_comb begin
      state_d     = state_q;
      sq_x_d      = sq_x_q;
      sq_y_d      = sq_y_q;
      cnt_d       = cnt_q;
      idx_d       = idx_q;
      snap_x_d    = snap_x_q;
      snap_y_d    = snap_y_q;
      snap_draw_d = snap_draw_q;
      pend_full_d = pend_full_q;
      pend_x_d    = pend_x_q;
      pend_y_d    = pend_y_q;
      pend_draw_d = pend_draw_q;
      x_d         = x_q;
      y_d         = y_q;
      colour_d    = colour_q;
      we_d        = 1'b0;
      ovf_d       = ovf_q;
      start       = 1'b0;
      start_x     = sq_x_q;
      start_y     = sq_y_q;
      start_draw  = draw;

      if (update && !finish_game) begin
         sq_y_d = sq_y_q + 7'd1;
         if (left && !right && sq_x_q != 8'd0) begin
            sq_x_d = sq_x_q - 8'd1;
         end else if (right && !left && sq_x_q < X_MAX) begin
            sq_x_d = sq_x_q + 8'd1;
         end
      end

      if (reset_count) begin
         cnt_d = '0;
      end else if (cnt_q < CNT_MAX) begin
         cnt_d = cnt_q + 1'b1;
      end

      case (state_q)
         S_IDLE: begin
            start = req;
         end
         S_SWEEP: begin
            if (idx_q != '1) begin
               idx_d = idx_q + 1'b1;
               we_d  = 1'b1;
               if (req) begin
                  if (pend_full_q) begin
                     ovf_d = 1'b1;
                  end else begin
                     pend_full_d = 1'b1;
                     pend_x_d    = sq_x_q;
                     pend_y_d    = sq_y_q;
                     pend_draw_d = draw;
                  end
               end
            end else if (pend_full_q) begin
               // Last pixel: hand the queued sweep over; the slot it frees can take a new request.
               start       = 1'b1;
               start_x     = pend_x_q;
               start_y     = pend_y_q;
               start_draw  = pend_draw_q;
               pend_full_d = req;
               if (req) begin
                  pend_x_d    = sq_x_q;
                  pend_y_d    = sq_y_q;
                  pend_draw_d = draw;
               end
            end else if (req) begin
               start = 1'b1;
            end else begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (start) begin
         state_d     = S_SWEEP;
         idx_d       = '0;
         snap_x_d    = start_x;
         snap_y_d    = start_y;
         snap_draw_d = start_draw;
         we_d        = 1'b1;
      end

      if (we_d) begin
         x_d      = snap_x_d + 8'(idx_d[SQ_LOG-1:0]);
         y_d      = snap_y_d + 7'(idx_d[IDX_W-1:SQ_LOG]);
         colour_d = snap_draw_d ? SQ_COLOUR : 3'b000;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         sq_x_q      <= X_INIT;
         sq_y_q      <= '0;
         cnt_q       <= '0;
         idx_q       <= '0;
         snap_x_q    <= '0;
         snap_y_q    <= '0;
         snap_draw_q <= 1'b0;
         pend_full_q <= 1'b0;
         pend_x_q    <= '0;
         pend_y_q    <= '0;
         pend_draw_q <= 1'b0;
         x_q         <= '0;
         y_q         <= '0;
         colour_q    <= '0;
         we_q        <= 1'b0;
         ovf_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         sq_x_q      <= sq_x_d;
         sq_y_q      <= sq_y_d;
         cnt_q       <= cnt_d;
         idx_q       <= idx_d;
         snap_x_q    <= snap_x_d;
         snap_y_q    <= snap_y_d;
         snap_draw_q <= snap_draw_d;
         pend_full_q <= pend_full_d;
         pend_x_q    <= pend_x_d;
         pend_y_q    <= pend_y_d;
         pend_draw_q <= pend_draw_d;
         x_q         <= x_d;
         y_q         <= y_d;
         colour_q    <= colour_d;
         we_q        <= we_d;
         ovf_q       <= ovf_d;
      end
   end

   assign x               = x_q;
   assign y               = y_q;
   assign colour          = colour_q;
   assign writeEn         = we_q;
   assign overflow        = ovf_q;
   assign finish_counting = (cnt_q == CNT_MAX);

endmodule

// File: tb/tb_meatsquare_datapath.sv
// Directed bench for meatsquare_datapath: reset, sweeps, queueing, overflow, counter, landing.
module tb_meatsquare_datapath;

   logic       clock = 1'b0;
   logic       reset;
   logic       update, plot, draw, erase, reset_count, left, right;
   logic [7:0] x;
   logic [6:0] y;
   logic [2:0] colour;
   logic       writeEn, finish_counting, finish_game, overflow;

   int n_checks = 0;
   int n_pass   = 0;

   meatsquare_datapath #(.FRAME_DELAY(10)) dut (
      .clock           (clock),
      .reset           (reset),
      .update          (update),
      .plot            (plot),
      .draw            (draw),
      .erase           (erase),
      .reset_count     (reset_count),
      .left            (left),
      .right           (right),
      .x               (x),
      .y               (y),
      .colour          (colour),
      .writeEn         (writeEn),
      .finish_counting (finish_counting),
      .finish_game     (finish_game),
      .overflow        (overflow)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      else n_pass++;
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic issue_draw();
      plot = 1'b1;
      draw = 1'b1;
      tick();
      plot = 1'b0;
      draw = 1'b0;
   endtask

   // Called in the first cycle after the request edge.
   task automatic expect_sweep(input string tag, input int x0, input int y0, input int c);
      for (int i = 0; i < 16; i++) begin
         check({tag, "_we"}, 32'(writeEn), 1);
         check({tag, "_x"},  32'(x), 32'(x0 + i % 4));
         check({tag, "_y"},  32'(y), 32'(y0 + i / 4));
         check({tag, "_c"},  32'(colour), 32'(c));
         tick();
      end
      check({tag, "_we_end"}, 32'(writeEn), 0);
   endtask

   initial begin
      int n_we;
      reset = 1'b0; update = 1'b0; plot = 1'b0; draw = 1'b0; erase = 1'b0;
      reset_count = 1'b0; left = 1'b0; right = 1'b0;

      repeat (3) @(posedge clock);
      #1;
      reset = 1'b1;
      check("rst_we",  32'(writeEn), 0);
      check("rst_x",   32'(x), 0);
      check("rst_y",   32'(y), 0);
      check("rst_col", 32'(colour), 0);
      check("rst_fg",  32'(finish_game), 0);
      check("rst_ovf", 32'(overflow), 0);
      check("rst_fc",  32'(finish_counting), 0);
      tick();

      issue_draw();
      expect_sweep("draw", 78, 0, 4);
      check("hold_x", 32'(x), 81);
      check("hold_y", 32'(y), 3);

      // erase@t, update+right@t+1, draw@t+2
      plot = 1'b1; erase = 1'b1;
      tick();
      plot = 1'b0; erase = 1'b0; update = 1'b1; right = 1'b1;
      for (int k = 0; k < 32; k++) begin
         if (k == 1) begin
            update = 1'b0; right = 1'b0; plot = 1'b1; draw = 1'b1;
         end else if (k == 2) begin
            plot = 1'b0; draw = 1'b0;
         end
         check("seq_we", 32'(writeEn), 1);
         check("seq_x",  32'(x), (k < 16) ? 32'(78 + k % 4) : 32'(79 + (k - 16) % 4));
         check("seq_y",  32'(y), (k < 16) ? 32'(k / 4) : 32'(1 + (k - 16) / 4));
         check("seq_c",  32'(colour), (k < 16) ? 0 : 4);
         tick();
      end
      check("seq_we_end", 32'(writeEn), 0);
      check("seq_ovf", 32'(overflow), 0);

      // three back-to-back requests: one sweeps, one queues, one is dropped
      plot = 1'b1; draw = 1'b1;
      tick();
      n_we = 0;
      for (int i = 1; i <= 40; i++) begin
         if (i == 3) begin
            plot = 1'b0; draw = 1'b0;
            check("ovf_set", 32'(overflow), 1);
         end
         if (i == 2) check("ovf_pre", 32'(overflow), 0);
         n_we += int'(writeEn);
         tick();
      end
      check("ovf_we_count", 32'(n_we), 32);
      check("ovf_sticky", 32'(overflow), 1);
      reset = 1'b0;
      tick();
      reset = 1'b1;
      check("ovf_clr", 32'(overflow), 0);

      reset_count = 1'b1;
      tick();
      reset_count = 1'b0;
      for (int k = 1; k <= 12; k++) begin
         check("cnt_fc", 32'(finish_counting), (k >= 10) ? 1 : 0);
         if (k == 12) reset_count = 1'b1;
         tick();
      end
      reset_count = 1'b0;
      check("cnt_restart", 32'(finish_counting), 0);

      // position is (78,0): walk left into the wall while falling
      left = 1'b1; update = 1'b1;
      repeat (80) tick();
      update = 1'b0; left = 1'b0;
      check("fg_y80", 32'(finish_game), 0);
      issue_draw();
      expect_sweep("clamp", 0, 80, 4);
      update = 1'b1;
      repeat (35) tick();
      update = 1'b0;
      check("fg_y115", 32'(finish_game), 0);
      update = 1'b1;
      tick();
      update = 1'b0;
      check("fg_y116", 32'(finish_game), 1);
      update = 1'b1; right = 1'b1;
      tick();
      update = 1'b0; right = 1'b0;
      check("fg_frozen", 32'(finish_game), 1);
      issue_draw();
      expect_sweep("land", 0, 116, 4);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
